// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared limits and width helpers for the SRAM port arbiter
package sram_port_arbiter_pkg;

  localparam int MIN_NUM_CH     = 2;
  localparam int MAX_NUM_CH     = 8;
  localparam int MIN_RD_LATENCY = 1;
  localparam int MAX_RD_LATENCY = 4;

  // Ceiling log2, evaluated at elaboration time for parameter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // Channel id width; never narrower than one bit.
  function automatic int ch_id_width(input int num_ch);
    return (num_ch <= 2) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// rtl/sram_port_arbiter_rr_arbiter.sv - round-robin arbiter with per-channel grant lock
module sram_port_arbiter_rr_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = ch_id_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] lock,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     grant_id,
  output logic              grant_valid
);

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;
  logic [CW-1:0] idx_c;
  logic          found;
  int            idx;

  // Search from ptr upward (mod NUM_CH); first requester wins, ptr moves past it unless it locks.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    ptr_d       = ptr_q;
    found       = 1'b0;
    idx         = 0;
    idx_c       = '0;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        idx_c = CW'(idx);
        if (!found && req[idx_c]) begin
          found        = 1'b1;
          grant[idx_c] = 1'b1;
          grant_id     = idx_c;
          grant_valid  = 1'b1;
          if (lock[idx_c]) ptr_d = idx_c;
          else if (idx_c == CW'(NUM_CH - 1)) ptr_d = '0;
          else ptr_d = idx_c + CW'(1);
        end
      end
    end
  end

  // Priority pointer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - multi-client arbiter onto a dual-port (read/write) SRAM
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int AW         = 18,
  parameter int DW         = 16,
  parameter int NUM_CH     = 4,
  parameter int RD_LATENCY = 1,
  parameter int CW         = ch_id_width(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    rd_req,
  input  logic [NUM_CH-1:0]    rd_lock,
  input  logic [NUM_CH*AW-1:0] rd_addr,
  output logic [NUM_CH-1:0]    rd_ack,
  output logic [NUM_CH-1:0]    rd_valid,
  output logic [DW-1:0]        rd_data,
  input  logic [NUM_CH-1:0]    wr_req,
  input  logic [NUM_CH-1:0]    wr_lock,
  input  logic [NUM_CH*AW-1:0] wr_addr,
  input  logic [NUM_CH*DW-1:0] wr_data,
  output logic [NUM_CH-1:0]    wr_ack,
  output logic [AW-1:0]        sram_raddr,
  input  logic [DW-1:0]        sram_rdata,
  output logic [AW-1:0]        sram_waddr,
  output logic [DW-1:0]        sram_wdata,
  output logic                 sram_wr_enable
);

  if (NUM_CH < MIN_NUM_CH || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
    $error("sram_port_arbiter: NUM_CH out of range");
  end
  if (RD_LATENCY < MIN_RD_LATENCY || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
    $error("sram_port_arbiter: RD_LATENCY out of range");
  end

  logic [CW-1:0] rd_id;
  logic          rd_gv;
  logic [CW-1:0] wr_id;
  logic          wr_gv;

  sram_port_arbiter_rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_rd_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (rd_req),
    .lock        (rd_lock),
    .grant       (rd_ack),
    .grant_id    (rd_id),
    .grant_valid (rd_gv)
  );

  sram_port_arbiter_rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_wr_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (wr_req),
    .lock        (wr_lock),
    .grant       (wr_ack),
    .grant_id    (wr_id),
    .grant_valid (wr_gv)
  );

  logic [AW-1:0] sram_raddr_q, sram_raddr_d;
  logic [AW-1:0] sram_waddr_q, sram_waddr_d;
  logic [DW-1:0] sram_wdata_q, sram_wdata_d;
  logic          sram_wr_enable_q, sram_wr_enable_d;

  // Stage 0 is loaded alongside sram_raddr; the last stage lines up with sram_rdata.
  logic          tag_vld_q [RD_LATENCY+1];
  logic          tag_vld_d [RD_LATENCY+1];
  logic [CW-1:0] tag_id_q  [RD_LATENCY+1];
  logic [CW-1:0] tag_id_d  [RD_LATENCY+1];

  // Select the granted channel's address/data; address and data hold when nothing is granted.
  always_comb begin
    sram_raddr_d     = sram_raddr_q;
    sram_waddr_d     = sram_waddr_q;
    sram_wdata_d     = sram_wdata_q;
    sram_wr_enable_d = wr_gv;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_gv && rd_id == CW'(i)) sram_raddr_d = rd_addr[i*AW +: AW];
      if (wr_gv && wr_id == CW'(i)) begin
        sram_waddr_d = wr_addr[i*AW +: AW];
        sram_wdata_d = wr_data[i*DW +: DW];
      end
    end
  end

  // Shift the read channel tags toward the return side.
  always_comb begin
    tag_vld_d[0] = rd_gv;
    tag_id_d[0]  = rd_id;
    for (int i = 1; i <= RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // SRAM-side registers and tag pipe; reset drops any read still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_raddr_q     <= '0;
      sram_waddr_q     <= '0;
      sram_wdata_q     <= '0;
      sram_wr_enable_q <= 1'b0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
    end else begin
      sram_raddr_q     <= sram_raddr_d;
      sram_waddr_q     <= sram_waddr_d;
      sram_wdata_q     <= sram_wdata_d;
      sram_wr_enable_q <= sram_wr_enable_d;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_d[i];
        tag_id_q[i]  <= tag_id_d[i];
      end
    end
  end

  // Decode the returning tag into a one-hot strobe; data is broadcast straight from the SRAM.
  always_comb begin
    rd_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tag_vld_q[RD_LATENCY] && tag_id_q[RD_LATENCY] == CW'(i)) rd_valid[i] = 1'b1;
    end
  end

  assign rd_data        = sram_rdata;
  assign sram_raddr     = sram_raddr_q;
  assign sram_waddr     = sram_waddr_q;
  assign sram_wdata     = sram_wdata_q;
  assign sram_wr_enable = sram_wr_enable_q;

endmodule
